// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a carry-flag register, a
// start/ready/done handshake and iterative multiply / variable shift.
//
// Ports
//   clk      rising-edge clock for all state
//   reset_n  asynchronous active-low reset
//   start    issue request, only sampled while ready=1
//   op       5-bit opcode
//   in_a     operand A
//   in_b     operand B (SHLN/SHRN take the count from in_b[SHW-1:0])
//   ready    high while idle and able to accept an op
//   done     one-cycle pulse when result and flags are valid
//   result   registered result, held until the next done
//   c_o      carry flag register (also the carry-in)
//   zero     registered zero flag
//   equal    registered equality flag (CMP only)
//   gt       registered signed greater-than flag (CMP only)
//   lt       registered signed less-than flag (CMP only)
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_o,
   output logic             zero,
   output logic             equal,
   output logic             gt,
   output logic             lt
);

   localparam int SHW = $clog2(WIDTH);

   localparam logic [4:0] OP_DEC  = 5'b00010;
   localparam logic [4:0] OP_CMP  = 5'b00101;
   localparam logic [4:0] OP_ADD  = 5'b00111;
   localparam logic [4:0] OP_CLC  = 5'b01000;
   localparam logic [4:0] OP_SUB  = 5'b01110;
   localparam logic [4:0] OP_AND  = 5'b01111;
   localparam logic [4:0] OP_XOR  = 5'b10000;
   localparam logic [4:0] OP_LSR  = 5'b10001;
   localparam logic [4:0] OP_RRC  = 5'b10010;
   localparam logic [4:0] OP_LSL  = 5'b10011;
   localparam logic [4:0] OP_RLC  = 5'b10100;
   localparam logic [4:0] OP_OR   = 5'b10101;
   localparam logic [4:0] OP_ASR  = 5'b11000;
   localparam logic [4:0] OP_MUL  = 5'b11001;
   localparam logic [4:0] OP_SHLN = 5'b11010;
   localparam logic [4:0] OP_SHRN = 5'b11011;

   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MULT  = 2'd1,
      S_SHIFT = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 c_q, c_d;
   logic                 zero_q, zero_d;
   logic                 eq_q, eq_d;
   logic                 gt_q, gt_d;
   logic                 lt_q, lt_d;
   logic                 done_q, done_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [WIDTH-1:0]     shreg_q, shreg_d;
   logic                 dir_q, dir_d;      // 1 = shift left
   logic [SHW-1:0]       cnt_q, cnt_d;

   logic [WIDTH:0]       add_sum_s, sub_sum_s;
   logic [2*WIDTH-1:0]   acc_nxt_s;
   logic [SHW-1:0]       n_s;
   logic                 is_shift_s;
   logic [WIDTH-1:0]     in_sh_s, sh_nxt_s;
   logic                 in_out_s, sh_out_s;
   logic [WIDTH-1:0]     r_s;
   logic                 wr_s;

   // SUB is A + ~B + cf, so cf=1 means "no borrow".
   assign add_sum_s  = {1'b0, in_a} + {1'b0, in_b}  + {{WIDTH{1'b0}}, c_q};
   assign sub_sum_s  = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, c_q};
   assign acc_nxt_s  = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});
   assign n_s        = in_b[SHW-1:0];
   assign is_shift_s = (op == OP_SHLN) || (op == OP_SHRN);
   // The first bit of a variable shift is taken straight from in_a on the
   // start edge, giving a latency of max(n,1) edges.
   assign in_sh_s    = (op == OP_SHLN) ? {in_a[WIDTH-2:0], 1'b0} : {1'b0, in_a[WIDTH-1:1]};
   assign in_out_s   = (op == OP_SHLN) ? in_a[WIDTH-1] : in_a[0];
   assign sh_nxt_s   = dir_q ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
   assign sh_out_s   = dir_q ? shreg_q[WIDTH-1] : shreg_q[0];

   assign ready  = (state_q == S_IDLE);
   assign done   = done_q;
   assign result = result_q;
   assign c_o    = c_q;
   assign zero   = zero_q;
   assign equal  = eq_q;
   assign gt     = gt_q;
   assign lt     = lt_q;

   // Next-state, datapath and flag computation.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      c_d      = c_q;
      zero_d   = zero_q;
      eq_d     = eq_q;
      gt_d     = gt_q;
      lt_d     = lt_q;
      done_d   = 1'b0;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      shreg_d  = shreg_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      r_s      = result_q;
      wr_s     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
                  acc_d    = {(2*WIDTH){1'b0}};
                  mcand_d  = {{WIDTH{1'b0}}, in_a};
                  mplier_d = in_b;
                  cnt_d    = {SHW{1'b0}};
                  state_d  = S_MULT;
               end else if (is_shift_s && (n_s > CNT_ONE)) begin
                  shreg_d = in_sh_s;
                  dir_d   = (op == OP_SHLN);
                  cnt_d   = n_s - CNT_ONE;
                  state_d = S_SHIFT;
               end else begin
                  // Single-cycle op: result and flags land on this edge.
                  done_d = 1'b1;
                  eq_d   = 1'b0;
                  gt_d   = 1'b0;
                  lt_d   = 1'b0;
                  wr_s   = 1'b1;
                  case (op)
                     OP_ADD: begin r_s = add_sum_s[WIDTH-1:0]; c_d = add_sum_s[WIDTH]; end
                     OP_SUB: begin r_s = sub_sum_s[WIDTH-1:0]; c_d = sub_sum_s[WIDTH]; end
                     OP_DEC: r_s = in_a - {{(WIDTH-1){1'b0}}, 1'b1};
                     OP_XOR: r_s = in_a ^ in_b;
                     OP_AND: r_s = in_a & in_b;
                     OP_OR:  r_s = in_a | in_b;
                     OP_LSR: begin r_s = {1'b0, in_a[WIDTH-1:1]};      c_d = in_a[0];       end
                     OP_LSL: begin r_s = {in_a[WIDTH-2:0], 1'b0};      c_d = in_a[WIDTH-1]; end
                     OP_RRC: begin r_s = {c_q, in_a[WIDTH-1:1]};       c_d = in_a[0];       end
                     OP_RLC: begin r_s = {in_a[WIDTH-2:0], c_q};       c_d = in_a[WIDTH-1]; end
                     OP_ASR: begin r_s = {in_a[WIDTH-1], in_a[WIDTH-1:1]}; c_d = in_a[0];   end
                     OP_CMP: begin
                        wr_s   = 1'b0;
                        eq_d   = (in_a == in_b);
                        zero_d = (in_a == in_b);
                        gt_d   = ($signed(in_a) > $signed(in_b));
                        lt_d   = ($signed(in_a) < $signed(in_b));
                     end
                     OP_CLC: begin wr_s = 1'b0; c_d = 1'b0; end
                     // Only n=0 and n=1 reach here; n=0 passes A through.
                     OP_SHLN, OP_SHRN: begin
                        if (n_s == {SHW{1'b0}}) begin
                           r_s = in_a;
                        end else begin
                           r_s = in_sh_s;
                           c_d = in_out_s;
                        end
                     end
                     default: r_s = {WIDTH{1'b0}};
                  endcase
               end
            end else begin
               state_d = S_IDLE;
            end
         end

         S_MULT: begin
            acc_d    = acc_nxt_s;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               wr_s    = 1'b1;
               r_s     = acc_nxt_s[WIDTH-1:0];
               c_d     = |acc_nxt_s[2*WIDTH-1:WIDTH];
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_MULT;
            end
         end

         S_SHIFT: begin
            shreg_d = sh_nxt_s;
            cnt_d   = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               wr_s    = 1'b1;
               r_s     = sh_nxt_s;
               c_d     = sh_out_s;
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               state_d = S_SHIFT;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (wr_s) begin
         result_d = r_s;
         zero_d   = (r_s == {WIDTH{1'b0}});
      end else begin
         result_d = result_q;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         result_q <= {WIDTH{1'b0}};
         c_q      <= 1'b0;
         zero_q   <= 1'b0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
         done_q   <= 1'b0;
         acc_q    <= {(2*WIDTH){1'b0}};
         mcand_q  <= {(2*WIDTH){1'b0}};
         mplier_q <= {WIDTH{1'b0}};
         shreg_q  <= {WIDTH{1'b0}};
         dir_q    <= 1'b0;
         cnt_q    <= {SHW{1'b0}};
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         c_q      <= c_d;
         zero_q   <= zero_d;
         eq_q     <= eq_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
         done_q   <= done_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         shreg_q  <= shreg_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (WIDTH=8).
// A behavioural model predicts every visible output each cycle; directed
// tests additionally pin results, flags and latencies to literal values.
module tb_alu_seq;

   logic       clk;
   logic       reset_n;
   logic       start;
   logic [4:0] op;
   logic [7:0] in_a, in_b;
   logic       ready, done, c_o, zero, equal, gt, lt;
   logic [7:0] result;

   int checks   = 0;
   int failures = 0;

   alu_seq #(.WIDTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .in_a(in_a), .in_b(in_b), .ready(ready), .done(done),
      .result(result), .c_o(c_o), .zero(zero), .equal(equal),
      .gt(gt), .lt(lt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] r;
      logic       c, z, eq, gt, lt;
   } vis_t;

   // Architectural effect of one op on the visible state.
   function automatic vis_t exec(input logic [4:0] o, input logic [7:0] a,
                                 input logic [7:0] b, input vis_t p);
      vis_t s;
      int   t;
      int   n;
      bit   wr;
      s = p; s.eq = 1'b0; s.gt = 1'b0; s.lt = 1'b0;
      wr = 1'b1;
      n = int'(b[2:0]);
      case (o)
         5'b00111: begin t = int'(a) + int'(b) + int'(p.c); s.r = 8'(t); s.c = (t > 255); end
         5'b01110: begin t = int'(a) - int'(b) - (p.c ? 0 : 1); s.r = 8'(t); s.c = (t >= 0); end
         5'b00010: s.r = 8'(int'(a) - 1);
         5'b10000: s.r = a ^ b;
         5'b01111: s.r = a & b;
         5'b10101: s.r = a | b;
         5'b10001: begin s.r = 8'(int'(a) / 2); s.c = a[0]; end
         5'b10011: begin s.r = 8'(int'(a) * 2); s.c = a[7]; end
         5'b10010: begin s.r = 8'(int'(a) / 2 + (p.c ? 128 : 0)); s.c = a[0]; end
         5'b10100: begin s.r = 8'(int'(a) * 2 + int'(p.c)); s.c = a[7]; end
         5'b11000: begin s.r = 8'(int'(a) / 2 + (a[7] ? 128 : 0)); s.c = a[0]; end
         5'b00101: begin
            wr = 1'b0;
            s.eq = (a == b); s.z = (a == b);
            s.gt = ($signed(a) > $signed(b));
            s.lt = ($signed(a) < $signed(b));
         end
         5'b01000: begin wr = 1'b0; s.c = 1'b0; end
         5'b11001: begin t = int'(a) * int'(b); s.r = 8'(t); s.c = (t > 255); end
         5'b11010: begin
            if (n == 0) s.r = a;
            else begin s.r = 8'(int'(a) << n); s.c = ((int'(a) >> (8 - n)) & 1) != 0; end
         end
         5'b11011: begin
            if (n == 0) s.r = a;
            else begin s.r = 8'(int'(a) >> n); s.c = ((int'(a) >> (n - 1)) & 1) != 0; end
         end
         default: s.r = 8'h00;
      endcase
      if (wr) s.z = (s.r == 8'h00);
      return s;
   endfunction

   // Edges from the start edge (inclusive) to the edge that writes the result.
   function automatic int lat_of(input logic [4:0] o, input logic [7:0] b);
      if (o == 5'b11001) return 9;
      if (o == 5'b11010 || o == 5'b11011) return (b[2:0] == 3'd0) ? 1 : int'(b[2:0]);
      return 1;
   endfunction

   vis_t m_vis, m_pend;
   logic m_done, m_busy;
   int   m_rem;

   // Reference model: accepts starts only while idle, commits after the latency.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_vis <= '0; m_pend <= '0; m_done <= 1'b0; m_busy <= 1'b0; m_rem <= 0;
      end else if (m_busy) begin
         m_done <= 1'b0;
         m_rem  <= m_rem - 1;
         if (m_rem == 1) begin
            m_vis <= m_pend; m_done <= 1'b1; m_busy <= 1'b0;
         end
      end else if (start) begin
         if (lat_of(op, in_b) == 1) begin
            m_vis <= exec(op, in_a, in_b, m_vis); m_done <= 1'b1;
         end else begin
            m_pend <= exec(op, in_a, in_b, m_vis); m_busy <= 1'b1;
            m_rem  <= lat_of(op, in_b) - 1; m_done <= 1'b0;
         end
      end else begin
         m_done <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      chk("m_done",   32'(done),   32'(m_done));
      chk("m_ready",  32'(ready),  32'(!m_busy));
      chk("m_result", 32'(result), 32'(m_vis.r));
      chk("m_flags",  {27'd0, c_o, zero, equal, gt, lt},
                      {27'd0, m_vis.c, m_vis.z, m_vis.eq, m_vis.gt, m_vis.lt});
   end

   // Issue one op and wait (bounded) for done; pin result, carry and latency.
   task automatic issue(input string nm, input logic [4:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic ec,
                        input int elat);
      int lat;
      @(negedge clk);
      start = 1'b1; op = o; in_a = a; in_b = b;
      @(negedge clk);
      start = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
      lat = 1;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, "_lat"}, 32'(lat), 32'(elat));
      chk({nm, "_r"},   32'(result), 32'(er));
      chk({nm, "_c"},   32'(c_o), 32'(ec));
   endtask

   initial begin
      int ndone, first;
      reset_n = 1'b0; start = 1'b0; op = 5'd0; in_a = 8'd0; in_b = 8'd0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready",  32'(ready), 32'd1);
      chk("rst_done",   32'(done), 32'd0);
      chk("rst_result", 32'(result), 32'd0);
      #1 reset_n = 1'b1;

      issue("dec0", 5'b00010, 8'h00, 8'h00, 8'hFF, 1'b0, 1);

      // Reset in the middle of a multiply.
      @(negedge clk);
      start = 1'b1; op = 5'b11001; in_a = 8'h03; in_b = 8'h05;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_ready",  32'(ready), 32'd1);
      chk("midrst_result", 32'(result), 32'd0);
      chk("midrst_flags",  {27'd0, c_o, zero, equal, gt, lt}, 32'd0);
      @(negedge clk);
      #2 reset_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("midrst_nodone", 32'(done), 32'd0);

      issue("add",  5'b00111, 8'hF0, 8'h20, 8'h10, 1'b1, 1);
      issue("clc",  5'b01000, 8'h00, 8'h00, 8'h10, 1'b0, 1);
      issue("sub1", 5'b01110, 8'h05, 8'h03, 8'h01, 1'b1, 1);
      issue("sub2", 5'b01110, 8'h03, 8'h05, 8'hFE, 1'b0, 1);
      issue("cmp1", 5'b00101, 8'h80, 8'h01, 8'hFE, 1'b0, 1);
      chk("cmp1_flags", {29'd0, equal, gt, lt}, 32'b001);
      issue("cmp2", 5'b00101, 8'h7F, 8'h7F, 8'hFE, 1'b0, 1);
      chk("cmp2_eqz", {30'd0, equal, zero}, 32'b11);

      // Multiply with a start pulse while busy that must be ignored.
      @(negedge clk);
      start = 1'b1; op = 5'b11001; in_a = 8'h10; in_b = 8'h11;
      ndone = 0; first = 0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (first == 0) first = k;
         end
         start = (k == 3);
         op = 5'b00111; in_a = 8'($urandom); in_b = 8'($urandom);
      end
      start = 1'b0;
      chk("mul_lat",   32'(first), 32'd9);
      chk("mul_ndone", 32'(ndone), 32'd1);
      chk("mul_r",     32'(result), 32'h10);
      chk("mul_c",     32'(c_o), 32'd1);

      issue("shrn3", 5'b11011, 8'h81, 8'h03, 8'h10, 1'b0, 3);
      issue("shln1", 5'b11010, 8'hC0, 8'h01, 8'h80, 1'b1, 1);
      issue("shln0", 5'b11010, 8'h5A, 8'h08, 8'h5A, 1'b1, 1);
      issue("shln7", 5'b11010, 8'h03, 8'h07, 8'h80, 1'b1, 7);
      issue("asr",   5'b11000, 8'h81, 8'h00, 8'hC0, 1'b1, 1);
      issue("clc2",  5'b01000, 8'h00, 8'h00, 8'hC0, 1'b0, 1);

      // Back-to-back single-cycle ops.
      @(negedge clk);
      start = 1'b1; op = 5'b10000; in_a = 8'hF0; in_b = 8'h3C;
      @(negedge clk);
      chk("b2b_xor", {23'd0, done, result}, {23'd0, 1'b1, 8'hCC});
      op = 5'b01111;
      @(negedge clk);
      chk("b2b_and", {23'd0, done, result}, {23'd0, 1'b1, 8'h30});
      op = 5'b10100; in_a = 8'h81;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_rlc", {22'd0, done, c_o, result}, {22'd0, 1'b1, 1'b1, 8'h02});

      issue("unk", 5'b11111, 8'h55, 8'hAA, 8'h00, 1'b1, 1);
      chk("unk_zero", 32'(zero), 32'd1);

      repeat (3) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 8-bit datapath ALU.
- Adds an internal carry-flag register and a start/ready/done handshake.
- Adds iterative multi-cycle ops: multiply, and shift by a variable amount.
- Sits between the register file read ports and the writeback mux. The control unit issues one op, then waits for done before writing result and flags.

Parameters:
- WIDTH, 8, datapath width in bits; must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk, input, 1, rising-edge clock for all state.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, issue request; sampled only when ready=1.
- op, input, 5, opcode, encodings listed under Behaviour.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B; SHLN/SHRN use in_b[SHW-1:0] as the shift count.
- ready, output, 1, high in IDLE.
- done, output, 1, one-cycle pulse when result and flags are valid.
- result, output, WIDTH, registered result; held until the next done.
- c_o, output, 1, carry flag register; it also supplies carry-in.
- zero, output, 1, registered zero flag.
- equal, output, 1, registered equality flag (CMP only).
- gt, output, 1, registered signed greater-than flag (CMP only).
- lt, output, 1, registered signed less-than flag (CMP only).

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - result=0, c_o=0, zero=0, equal=0, gt=0, lt=0, done=0, ready=1.
  - Any in-flight op is discarded with no done.
- FSM states: IDLE, MULT, SHIFT.
- IDLE with start=1, single-cycle op:
  - Operands and op latched at that edge; result and flags written at the same edge; done=1 for the following cycle.
  - Latency is 1 edge; state stays IDLE, so back-to-back issue is allowed every cycle.
- IDLE with start=1, MUL → MULT; IDLE with start=1, SHLN/SHRN → SHIFT.
  - Operands are captured internally; in_a/in_b may change after the start edge.
  - ready=0 until the op completes; start while ready=0 is ignored with no queueing.
- Single-cycle ops (cf = c_o before the op; all widths WIDTH unless stated):
  - 00111 ADD: {c,r}=A+B+cf.
  - 01110 SUB: {c,r}=A+~B+cf, i.e. cf=1 means no borrow.
  - 00010 DEC: r=A-1; c unchanged.
  - 10000 XOR, 01111 AND, 10101 OR: bitwise; c unchanged.
  - 10001 LSR: c=A[0], r={0,A[W-1:1]}.
  - 10011 LSL: c=A[W-1], r={A[W-2:0],0}.
  - 10010 RRC: c=A[0], r={cf,A[W-1:1]}.
  - 10100 RLC: c=A[W-1], r={A[W-2:0],cf}.
  - 11000 ASR: c=A[0], r={A[W-1],A[W-1:1]}.
  - 00101 CMP, signed compare:
    - equal=zero=(A==B), gt=(A>B), lt=(A<B).
    - result unchanged, c unchanged.
  - 01000 CLC: c=0; result unchanged.
- Flag update rules:
  - zero=(r==0) for every non-CMP op that writes result.
  - equal/gt/lt are cleared by every op except CMP.
- MUL (11001), unsigned shift-add:
  - Exactly WIDTH cycles in MULT, one multiplier bit per cycle, using a 2·WIDTH-bit accumulator.
  - At exit: result=product[W-1:0], c=|product[2W-1:W] (overflow), zero=(result==0).
  - done pulses the cycle after the last iteration edge, so done appears WIDTH+1 edges after the start edge.
- SHLN (11010) / SHRN (11011), logical shift by n=in_b[SHW-1:0]:
  - One bit per cycle in SHIFT; c = last bit shifted out.
  - n=0: no iteration; completes next edge like a single-cycle op, result=A, c unchanged.
  - Latency is max(n,1) edges.
- Unknown opcode: result=0, zero=1, equal/gt/lt=0, c unchanged, done pulses; treated as single-cycle.
- done is high for exactly one cycle per accepted start.
- result and flags are stable between done pulses.

Test Plan:
- Reset then ADD: reset_n low mid-MUL → all outputs 0, ready=1 immediately; ADD A=0xF0, B=0x20, cf=0 → result 0x10, c_o=1, done 1 cycle later.
- Carry chain: CLC, then SUB 0x05−0x03 → result 0x01, c_o=1; then SUB 0x03−0x05 (cf=1) → result 0xFE, c_o=0.
- CMP signed: A=0x80 (−128), B=0x01 → lt=1, gt=0, equal=0, result unchanged; A=B=0x7F → equal=zero=1.
- MUL: A=0x10, B=0x11 → done 9 edges after start, result 0x10, c_o=1; start pulsed while busy is ignored (exactly one done).
- Variable shifts: SHRN A=0x81, n=3 → result 0x10, c_o=0, latency 3; SHLN A=0xC0, n=1 → 0x80, c_o=1; SHLN n=0 → result=A, latency 1.
- Back-to-back: XOR, AND, RLC issued on consecutive cycles → three consecutive done pulses with correct results; unknown op 11111 → result 0, zero=1.
